// File: rtl/fpu_seq_pkg.sv
// Shared types for the FPU chain sequencer.
// Holds the FSM encoding, the FPU op codes and the op legality check.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LAUNCH,
        WAIT,
        CAPTURE,
        NEXT
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/fpu_seq_acc_bank.sv
// Per-channel accumulator registers for the FPU chain sequencer.
// One write port, one broadcast load port and one read mux.
module fpu_seq_acc_bank #(
    parameter int                DATA_W   = 64,
    parameter int                NUM_CH   = 4,
    parameter int                CW       = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CW-1:0]     rd_ch,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] acc_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= INIT_VAL;
            end
        end else if (ld_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= ld_data;
            end
        end else if (wr_en) begin
            acc_q[wr_ch] <= wr_data;
        end
    end

    assign rd_data = acc_q[rd_ch];

endmodule

// File: rtl/fpu_chain_sequencer.sv
// Sequences one FPU operation per channel on every sample strobe,
// feeding each result back into that channel's accumulator.
module fpu_chain_sequencer #(
    parameter int                DATA_W    = 64,
    parameter int                NUM_CH    = 4,
    parameter int                EN_CYCLES = 2,
    parameter int                TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0,
    localparam int               CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_strobe,
    input  logic [NUM_CH*DATA_W-1:0] ch_opa,
    input  logic [NUM_CH*3-1:0]      ch_op,
    input  logic [1:0]               rmode,
    input  logic                     acc_load,
    input  logic [DATA_W-1:0]        acc_load_val,
    output logic                     fpu_enable,
    output logic [2:0]               fpu_op,
    output logic [1:0]               fpu_rmode,
    output logic [DATA_W-1:0]        fpu_opa,
    output logic [DATA_W-1:0]        fpu_opb,
    input  logic [DATA_W-1:0]        fpu_out,
    input  logic                     fpu_ready,
    input  logic                     fpu_exception,
    output logic                     res_valid,
    output logic [CW-1:0]            res_ch,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_exc,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err,
    output logic                     illegal_op
);

    import fpu_seq_pkg::*;

    localparam int EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic [EW-1:0] EN_LAST = EW'(EN_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     ch_q;
    logic [EW-1:0]     en_cnt_q;
    logic [TW-1:0]     wait_cnt_q;
    logic [2:0]        op_arr  [NUM_CH];
    logic [DATA_W-1:0] opa_arr [NUM_CH];
    logic [2:0]        cur_op;
    logic [DATA_W-1:0] acc_rd;
    logic              op_ok;
    logic              got_ready;
    logic              acc_we;
    logic              acc_ld;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign op_arr[g]  = ch_op[g*3 +: 3];
        assign opa_arr[g] = ch_opa[g*DATA_W +: DATA_W];
    end

    assign cur_op     = op_arr[ch_q];
    assign op_ok      = is_legal_op(cur_op);
    assign got_ready  = (state_q == WAIT) && fpu_ready;
    assign acc_we     = (state_q == CAPTURE);
    assign acc_ld     = (state_q == IDLE) && acc_load;
    assign busy       = (state_q != IDLE);
    assign fpu_enable = (state_q == LAUNCH);

    fpu_seq_acc_bank #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .CW      (CW),
        .INIT_VAL(INIT_VAL)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (acc_we),
        .wr_ch  (ch_q),
        .wr_data(res_data),
        .ld_en  (acc_ld),
        .ld_data(acc_load_val),
        .rd_ch  (ch_q),
        .rd_data(acc_rd)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_strobe) state_d = CHECK;
            CHECK:   state_d = op_ok ? LAUNCH : NEXT;
            LAUNCH:  if (en_cnt_q == EN_LAST) state_d = WAIT;
            WAIT: begin
                if (fpu_ready) begin
                    state_d = CAPTURE;
                end else if (wait_cnt_q == TO_MAX) begin
                    state_d = NEXT;
                end
            end
            CAPTURE: state_d = NEXT;
            NEXT:    state_d = (ch_q == LAST_CH) ? IDLE : CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ch_q        <= '0;
            en_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            fpu_op      <= '0;
            fpu_rmode   <= '0;
            fpu_opa     <= '0;
            fpu_opb     <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data    <= '0;
            res_exc     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            en_cnt_q   <= (state_q == LAUNCH) ? en_cnt_q + 1'b1 : '0;
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
            res_valid  <= got_ready;

            if (state_q == IDLE && sample_strobe) begin
                ch_q <= '0;
            end else if (state_q == NEXT && ch_q != LAST_CH) begin
                ch_q <= ch_q + 1'b1;
            end

            // Operands are frozen here so later input changes cannot disturb the op.
            if (state_q == CHECK) begin
                if (op_ok) begin
                    fpu_op    <= cur_op;
                    fpu_rmode <= rmode;
                    fpu_opa   <= opa_arr[ch_q];
                    fpu_opb   <= acc_rd;
                end else begin
                    illegal_op <= 1'b1;
                end
            end

            if (got_ready) begin
                res_ch   <= ch_q;
                res_data <= fpu_out;
                res_exc  <= fpu_exception;
            end

            if (sample_strobe && state_q != IDLE) begin
                overrun <= 1'b1;
            end

            if (state_q == WAIT && !fpu_ready && wait_cnt_q == TO_MAX) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
